// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Purpose:
//   Loads a serial configuration shift-register chain of CHAIN_LENGTH bits from
//   a stream of WORD_WIDTH-bit host words. A load sequence is:
//   - clear the chain (cfg_nreset low for two cycles);
//   - accept a word;
//   - shift it out LSB first (one bit per cycle);
//   - repeat until CHAIN_LENGTH bits have been shifted;
//   - pulse done.
//   Surplus bits of the final word are dropped.
//
// Optional feature:
//   KFPGA_CONFIG_CRC_EN - when defined, crc accumulates a CRC-16-CCITT
//   (poly 0x1021, MSB-first feedback, init 0xFFFF) over the bits returned on
//   cfg_return during every shift cycle. When undefined, crc is tied to 0.
//
// Ports:
//   clock       in   single clock, rising edge
//   nreset      in   asynchronous active-low reset
//   start       in   request a full chain load (sampled only when idle)
//   word_data   in   host configuration word
//   word_valid  in   word_data valid
//   word_ready  out  word accepted this cycle when word_valid is also high
//   cfg_data    out  serial bit to the chain
//   cfg_enable  out  chain shift enable
//   cfg_nreset  out  active-low chain clear
//   cfg_return  in   serial bit returned from the end of the chain
//   busy        out  high whenever a load is in progress
//   done        out  one-cycle pulse at load completion
//   crc         out  checksum of the returned bitstream
// -----------------------------------------------------------------------------
module config_loader #(
  parameter int CHAIN_LENGTH = 524,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  input  logic                  cfg_return,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           crc
);

  localparam int BCW = $clog2(CHAIN_LENGTH + 1);
  localparam int WCW = $clog2(WORD_WIDTH + 1);

  // The bit counter counts completed shifts, so the final bit is the one
  // presented while the counter still reads CHAIN_LENGTH-1.
  localparam logic [BCW-1:0] LP_BIT_LAST  = BCW'(CHAIN_LENGTH - 1);
  localparam logic [BCW-1:0] LP_BIT_ONE   = BCW'(1);
  localparam logic [WCW-1:0] LP_WORD_LAST = WCW'(WORD_WIDTH);
  localparam logic [WCW-1:0] LP_WORD_ONE  = WCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [BCW-1:0]        r_bit_cnt;
  // Number of bits of the current word already presented (including the one
  // on cfg_data now).
  logic [WCW-1:0]        r_word_cnt;
  // Remaining, not yet presented, bits of the current word.
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_clear_cnt;
  logic                  r_word_ready;
  logic                  r_cfg_data;
  logic                  r_cfg_enable;
  logic                  r_cfg_nreset;
  logic                  r_busy;
  logic                  r_done;

`ifdef KFPGA_CONFIG_CRC_EN
  logic [15:0] r_crc;
  logic        w_crc_fb;
  logic [15:0] w_crc_next;

  always_comb begin
    w_crc_fb   = r_crc[15] ^ cfg_return;
    w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
  end

  assign crc = r_crc;
`else
  // Returned bitstream is not observed in this build.
  logic w_unused_return;
  assign w_unused_return = cfg_return;
  assign crc             = 16'h0000;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_shift      <= '0;
      r_clear_cnt  <= 1'b0;
      r_word_ready <= 1'b0;
      r_cfg_data   <= 1'b0;
      r_cfg_enable <= 1'b0;
      r_cfg_nreset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef KFPGA_CONFIG_CRC_EN
      r_crc        <= 16'hFFFF;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_CLEAR;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_clear_cnt  <= 1'b0;
            r_cfg_nreset <= 1'b0;
            r_busy       <= 1'b1;
`ifdef KFPGA_CONFIG_CRC_EN
            r_crc        <= 16'hFFFF;
`endif
          end
        end

        S_CLEAR: begin
          // cfg_nreset went low on entry; release after the second cycle.
          if (r_clear_cnt) begin
            r_state      <= S_LOAD;
            r_cfg_nreset <= 1'b1;
            r_word_ready <= 1'b1;
          end else begin
            r_clear_cnt <= 1'b1;
          end
        end

        S_LOAD: begin
          if (word_valid && r_word_ready) begin
            r_state      <= S_SHIFT;
            r_word_ready <= 1'b0;
            r_cfg_data   <= word_data[0];
            r_cfg_enable <= 1'b1;
            r_shift      <= word_data >> 1;
            r_word_cnt   <= LP_WORD_ONE;
          end
        end

        S_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + LP_BIT_ONE;
`ifdef KFPGA_CONFIG_CRC_EN
          r_crc     <= w_crc_next;
`endif
          if (r_bit_cnt == LP_BIT_LAST) begin
            // Chain full: any remaining bits of this word are dropped.
            r_state      <= S_DONE;
            r_cfg_enable <= 1'b0;
            r_cfg_data   <= 1'b0;
            r_done       <= 1'b1;
          end else if (r_word_cnt == LP_WORD_LAST) begin
            r_state      <= S_LOAD;
            r_cfg_enable <= 1'b0;
            r_cfg_data   <= 1'b0;
            r_word_ready <= 1'b1;
          end else begin
            r_cfg_data <= r_shift[0];
            r_shift    <= r_shift >> 1;
            r_word_cnt <= r_word_cnt + LP_WORD_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign word_ready = r_word_ready;
  assign cfg_data   = r_cfg_data;
  assign cfg_enable = r_cfg_enable;
  assign cfg_nreset = r_cfg_nreset;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
